// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: debounced mode/run buttons driving a 4-LED pattern generator
// stepped by a divided tick.
module led_pattern_ctrl #(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic       n_reset,
    input  logic       clock,
    input  logic       btn_mode,
    input  logic       btn_run,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       running
);
    localparam logic [1:0] COUNT  = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] BOUNCE = 2'd2;
    localparam logic [1:0] BLINK  = 2'd3;

    logic [1:0]  s1_q, s2_q, press;
    logic [3:0]  led_q, led_d;
    logic [1:0]  mode_q, mode_d;
    logic        running_q, running_d, up_q, up_d, tick;
    logic [30:0] tcnt_q, tcnt_d;

    always_ff @(posedge clock or negedge n_reset)
        if (!n_reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {btn_run, btn_mode};
            s2_q <= s1_q;
        end

    // bit 0 = mode button, bit 1 = run button
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [23:0] cnt_q;
        logic        lvl_q, differ, done;
        assign differ   = s2_q[b] ^ lvl_q;
        assign done     = differ && cnt_q == 24'(DEB_CYCLES - 1);
        assign press[b] = done && s2_q[b];
        always_ff @(posedge clock or negedge n_reset)
            if (!n_reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= (differ && !done) ? cnt_q + 24'd1 : '0;
                if (done) lvl_q <= s2_q[b];
            end
    end

    assign tick = running_q && tcnt_q == 31'(TICK_DIV - 1);

    always_comb begin
        mode_d    = press[0] ? mode_q + 2'd1 : mode_q;
        running_d = running_q ^ press[1];
        tcnt_d    = press[0] ? '0 : !running_q ? tcnt_q : tick ? '0 : tcnt_q + 31'd1;
        led_d     = led_q;
        up_d      = up_q;
        if (press[0]) begin
            led_d = (mode_d == SHIFT || mode_d == BOUNCE) ? 4'b0001 : 4'b0000;
            up_d  = 1'b1;
        end else if (tick) begin
            led_d = mode_q == COUNT ? led_q + 4'd1 :
                    mode_q == SHIFT ? {led_q[2:0], led_q[3]} :
                    mode_q == BLINK ? ~led_q :
                    up_q ? led_q << 1 : led_q >> 1;
            // direction flips on the step that lands on an end position
            if (mode_q == BOUNCE) up_d = up_q ? led_q != 4'b0100 : led_q == 4'b0010;
        end
    end

    always_ff @(posedge clock or negedge n_reset)
        if (!n_reset) begin
            led_q     <= 4'b0000;
            mode_q    <= COUNT;
            running_q <= 1'b1;
            up_q      <= 1'b1;
            tcnt_q    <= '0;
        end else begin
            led_q     <= led_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            up_q      <= up_d;
            tcnt_q    <= tcnt_d;
        end

    assign led     = led_q;
    assign mode    = mode_q;
    assign running = running_q;
endmodule
